// File: rtl/vde_sprite_fetch_ctrl_if.sv
// Sprite fetch controller bus bundle: line control, attribute table port, sprite memory port, line buffer write port.
// No latency of its own; pure wiring between the controller (master) and its environment (slave).
// No backpressure: the line buffer write port is a strobe that must be accepted every cycle it is high.
interface vde_sprite_fetch_ctrl_if #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 4
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_PER_LINE) + 1;
  localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  logic          line_start_i;
  logic [7:0]    line_i;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;
  logic [CW-1:0] count_o;
  logic [IW-1:0] attr_addr_o;
  logic [31:0]   attr_data_i;
  logic [10:0]   sprite_mem_addr_o;
  logic [31:0]   sprite_mem_data_i;
  logic          lb_we_o;
  logic [SW-1:0] lb_slot_o;
  logic          lb_word_o;
  logic [8:0]    lb_x_o;
  logic [31:0]   lb_data_o;

  modport master (
    input  line_start_i, line_i, attr_data_i, sprite_mem_data_i,
    output busy_o, done_o, overflow_o, count_o, attr_addr_o, sprite_mem_addr_o,
           lb_we_o, lb_slot_o, lb_word_o, lb_x_o, lb_data_o
  );

  modport slave (
    output line_start_i, line_i, attr_data_i, sprite_mem_data_i,
    input  busy_o, done_o, overflow_o, count_o, attr_addr_o, sprite_mem_addr_o,
           lb_we_o, lb_slot_o, lb_word_o, lb_x_o, lb_data_o
  );
endinterface

// File: rtl/vde_sprite_fetch_ctrl.sv
// Per-scanline sprite fetch sequencer: scans the attribute table, fetches 2 words per visible sprite into the line buffer.
// Latency: 3 cycles per invisible entry, 5 per fetched entry, plus start and done cycles; memories have 1-cycle read latency.
// No backpressure: line buffer writes are fire-and-forget; line_start while busy is dropped. Option macro: VDE_SPRITE_HFLIP_EN.
module vde_sprite_fetch_ctrl #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  vde_sprite_fetch_ctrl_if.master bus
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_PER_LINE) + 1;
  localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ATTR, S_CHK, S_FETCH0, S_FETCH1, S_NEXT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    line_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic [5:0]    tile_q;
  logic [3:0]    row_q;
  logic [8:0]    x_q;

  logic [7:0]    row_c;
  logic          vis_c;
  logic          full_c;
  logic          last_c;
  logic          flip_c;
  logic          flip_q;
  logic [31:0]   lb_pix_c;
  logic          unused_attr;

  logic [10:0]   mem_addr_c;
  logic          lb_we_c;
  logic          lb_word_c;
  logic          done_c;

  // Row within the sprite wraps modulo 256 so sprites straddling the top of the screen work.
  assign row_c  = line_q - bus.attr_data_i[7:0];
  assign vis_c  = bus.attr_data_i[31] && (row_c[7:4] == 4'd0);
  assign full_c = (cnt_q == CW'(MAX_PER_LINE));
  assign last_c = (idx_q == IW'(NUM_SPRITES - 1));

`ifdef VDE_SPRITE_HFLIP_EN
  // Mirror a row by reversing the 8 nibbles of a pixel word.
  function automatic logic [31:0] rev_nib(input logic [31:0] d);
    rev_nib = '0;
    for (int i = 0; i < 8; i++) rev_nib[4*i +: 4] = d[4*(7-i) +: 4];
  endfunction

  // A flipped sprite reads memory word 1 first so no buffering is needed.
  assign flip_c      = bus.attr_data_i[8];
  assign lb_pix_c    = flip_q ? rev_nib(bus.sprite_mem_data_i) : bus.sprite_mem_data_i;
  assign unused_attr = ^bus.attr_data_i[15:9];
`else
  assign flip_c      = 1'b0;
  assign flip_q      = 1'b0;
  assign lb_pix_c    = bus.sprite_mem_data_i;
  assign unused_attr = ^bus.attr_data_i[15:8];
`endif

  // State register; synchronous reset returns to IDLE and wins over a coincident start.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore/Mealy outputs for the scan sequence.
  always_comb begin
    state_d    = state_q;
    mem_addr_c = '0;
    lb_we_c    = 1'b0;
    lb_word_c  = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE:   if (bus.line_start_i) state_d = S_ATTR;
      S_ATTR:   state_d = S_CHK;
      S_CHK: begin
        if (vis_c) begin
          if (!full_c) begin
            mem_addr_c = {bus.attr_data_i[30:25], row_c[3:0], flip_c};
            state_d    = S_FETCH0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_NEXT;
        end
      end
      S_FETCH0: begin
        mem_addr_c = {tile_q, row_q, ~flip_q};
        lb_we_c    = 1'b1;
        state_d    = S_FETCH1;
      end
      S_FETCH1: begin
        lb_we_c   = 1'b1;
        lb_word_c = 1'b1;
        state_d   = S_NEXT;
      end
      S_NEXT:   state_d = last_c ? S_DONE : S_ATTR;
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Scan datapath: latched line, table index, fetch count, sticky overflow and per-sprite fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      tile_q <= '0;
      row_q  <= '0;
      x_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.line_start_i) begin
            line_q <= bus.line_i;
            idx_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
          end
        end
        S_CHK: begin
          if (vis_c && !full_c) begin
            tile_q <= bus.attr_data_i[30:25];
            row_q  <= row_c[3:0];
            x_q    <= bus.attr_data_i[24:16];
          end
          if (vis_c && full_c) ovf_q <= 1'b1;
        end
        S_FETCH1: cnt_q <= cnt_q + CW'(1);
        S_NEXT:   if (!last_c) idx_q <= idx_q + IW'(1);
        default: ;
      endcase
    end
  end

`ifdef VDE_SPRITE_HFLIP_EN
  // Flip flag of the sprite being fetched.
  always_ff @(posedge clk_i) begin
    if (rst_i)                               flip_q <= 1'b0;
    else if (state_q == S_CHK && vis_c && !full_c) flip_q <= flip_c;
  end
`endif

  assign bus.busy_o            = (state_q != S_IDLE);
  assign bus.done_o            = done_c;
  assign bus.overflow_o        = ovf_q;
  assign bus.count_o           = cnt_q;
  assign bus.attr_addr_o       = idx_q;
  assign bus.sprite_mem_addr_o = mem_addr_c;
  assign bus.lb_we_o           = lb_we_c;
  assign bus.lb_word_o         = lb_word_c;
  assign bus.lb_slot_o         = lb_we_c ? cnt_q[SW-1:0] : '0;
  assign bus.lb_x_o            = lb_we_c ? x_q : '0;
  assign bus.lb_data_o         = lb_we_c ? lb_pix_c : '0;
endmodule

// File: tb/tb_vde_sprite_fetch_ctrl.sv
// Scoreboard bench for the sprite fetch controller: directed scans, expected writes/done queued at issue time.
// Attribute table and sprite memory are modelled as 1-cycle-latency synchronous reads.
// Monitor checks every line buffer write and every done pulse against the queues.
module tb_vde_sprite_fetch_ctrl;
  localparam int NS = 16;
  localparam int MP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vde_sprite_fetch_ctrl_if #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) bus();
  vde_sprite_fetch_ctrl #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct {
    logic [10:0] addr;
    int          slot;
    logic        word;
    logic [8:0]  x;
    logic [31:0] data;
  } lb_exp_t;

  typedef struct {
    int   count;
    logic ovf;
    int   delta;
  } done_exp_t;

  logic [31:0] attr_tab [NS];
  logic [31:0] mem [2048];
  logic [10:0] mem_addr_q;
  lb_exp_t     lb_q[$];
  done_exp_t   done_q[$];
  int          cyc = 0;
  int          start_cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Synchronous memory models.
  always @(posedge clk) begin
    bus.attr_data_i       <= attr_tab[bus.attr_addr_o];
    bus.sprite_mem_data_i <= mem[bus.sprite_mem_addr_o];
    mem_addr_q            <= bus.sprite_mem_addr_o;
    cyc                   <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  lb_exp_t   me;
  done_exp_t md;
  always @(negedge clk) begin
    if (bus.lb_we_o) begin
      if (lb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lb_unexpected: write slot %0d word %0d data 0x%0h with nothing expected",
                 bus.lb_slot_o, bus.lb_word_o, bus.lb_data_o);
      end else begin
        me = lb_q.pop_front();
        chk("lb_mem_addr", 32'(mem_addr_q), 32'(me.addr));
        chk("lb_slot", 32'(bus.lb_slot_o), 32'(me.slot));
        chk("lb_word", 32'(bus.lb_word_o), 32'(me.word));
        chk("lb_x", 32'(bus.lb_x_o), 32'(me.x));
        chk("lb_data", bus.lb_data_o, me.data);
      end
    end else begin
      chk("lb_idle_data", bus.lb_data_o, 32'd0);
      chk("lb_idle_fields", 32'(bus.lb_x_o) | 32'(bus.lb_slot_o) | 32'(bus.lb_word_o), 32'd0);
    end
    if (bus.done_o) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done pulse with nothing expected (t=%0t)", $time);
      end else begin
        md = done_q.pop_front();
        chk("done_count", 32'(bus.count_o), 32'(md.count));
        chk("done_overflow", 32'(bus.overflow_o), 32'(md.ovf));
        chk("done_latency", 32'(cyc - start_cyc), 32'(md.delta));
      end
    end
  end

  function automatic logic [31:0] mk(input bit en, input int tile, input int x, input bit hf, input int y);
    return {en, 6'(tile), 9'(x), 7'd0, hf, 8'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_attrs();
    for (int i = 0; i < NS; i++) attr_tab[i] = 32'd0;
  endtask

  task automatic exp_wr(input logic [10:0] a, input int slot, input logic w, input int x, input logic [31:0] d);
    lb_exp_t e;
    e.addr = a; e.slot = slot; e.word = w; e.x = 9'(x); e.data = d;
    lb_q.push_back(e);
  endtask

  // Unflipped sprite: word 0 at a0 then word 1 at a0+1.
  task automatic exp_pair(input logic [10:0] a0, input int slot, input int x);
    exp_wr(a0, slot, 1'b0, x, mem[a0]);
    exp_wr(a0 + 11'd1, slot, 1'b1, x, mem[a0 + 11'd1]);
  endtask

  // delta = posedges from the one sampling the start to the one entering DONE
  // (start cycle and done cycle excluded, so the spec's 2+5+15*3 becomes 50).
  task automatic exp_done(input int count, input bit ovf, input int delta);
    done_exp_t d;
    d.count = count; d.ovf = ovf; d.delta = delta;
    done_q.push_back(d);
  endtask

  task automatic start(input int line);
    bus.line_i       = 8'(line);
    bus.line_start_i = 1'b1;
    tick();
    bus.line_start_i = 1'b0;
    start_cyc        = cyc;
    chk("busy_after_start", 32'(bus.busy_o), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((done_q.size() != 0) && (n < 400)) begin
      tick();
      n++;
    end
    if (done_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
      done_q.delete();
      lb_q.delete();
    end else begin
      chk({name, "_busy_clear"}, 32'(bus.busy_o), 32'd0);
      chk({name, "_writes_left"}, 32'(lb_q.size()), 32'd0);
    end
  endtask

  task automatic s1_setup();
    clear_attrs();
    attr_tab[0] = mk(1, 5, 100, 0, 10);
  endtask

  initial begin
    bus.line_start_i = 1'b0;
    bus.line_i       = 8'd0;
    clear_attrs();
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a) * 32'h9E3779B1 + 32'h12345678;

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_overflow", 32'(bus.overflow_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_attr_addr", 32'(bus.attr_addr_o), 32'd0);
    chk("rst_mem_addr", 32'(bus.sprite_mem_addr_o), 32'd0);
    chk("rst_lb_we", 32'(bus.lb_we_o), 32'd0);

    // Start coincident with reset: reset wins.
    s1_setup();
    rst = 1'b1; bus.line_i = 8'd13; bus.line_start_i = 1'b1;
    tick();
    rst = 1'b0; bus.line_start_i = 1'b0;
    chk("rst_start_busy", 32'(bus.busy_o), 32'd0);
    tick();
    chk("rst_start_busy2", 32'(bus.busy_o), 32'd0);

    // Single sprite: tile 5 row 3 -> 0x0A6/0x0A7; 1 fetched + 15 skipped = 5+45.
    s1_setup();
    exp_pair(11'h0A6, 0, 100);
    exp_done(1, 0, 50);
    start(13);
    wait_done("single");

    // All visible: entries 0..3 fetched at row 3, fifth check overflows: 4*5+2.
    for (int i = 0; i < NS; i++) attr_tab[i] = mk(1, i, 10 * i, 0, 0);
    for (int i = 0; i < 4; i++) exp_pair(11'(i * 32 + 6), i, 10 * i);
    exp_done(4, 1, 22);
    start(3);
    wait_done("overflow");
    chk("overflow_hold", 32'(bus.overflow_o), 32'd1);
    chk("count_hold", 32'(bus.count_o), 32'd4);

    // Wrap: y=250 line 5 -> row 11 (tile 7 -> 0x0F6); y=6 line 5 -> row 255, skipped.
    clear_attrs();
    attr_tab[2] = mk(1, 7, 300, 0, 250);
    attr_tab[5] = mk(1, 9, 50, 0, 6);
    exp_pair(11'h0F6, 0, 300);
    exp_done(1, 0, 50);
    start(5);
    wait_done("wrap");

    // Line 19: y=20 row 255 no; y=4 row 15 yes (0x19E); y=3 row 16 no;
    // disabled row 0 no; y=10 row 9 yes (tile 15 -> 0x1F2) in slot 1. 14*3+2*5.
    clear_attrs();
    attr_tab[2]  = mk(1, 7, 300, 0, 20);
    attr_tab[3]  = mk(1, 12, 1, 0, 4);
    attr_tab[7]  = mk(1, 13, 2, 0, 3);
    attr_tab[9]  = mk(0, 14, 3, 0, 19);
    attr_tab[11] = mk(1, 15, 511, 0, 10);
    exp_pair(11'h19E, 0, 1);
    exp_pair(11'h1F2, 1, 511);
    exp_done(2, 0, 52);
    start(19);
    wait_done("bounds");

    // Restart pulse mid-scan with line 99 is ignored.
    s1_setup();
    exp_pair(11'h0A6, 0, 100);
    exp_done(1, 0, 50);
    start(13);
    repeat (10) tick();
    bus.line_i = 8'd99; bus.line_start_i = 1'b1;
    tick();
    bus.line_start_i = 1'b0;
    wait_done("restart");

    // Start pulse during the done cycle is ignored.
    exp_pair(11'h0A6, 0, 100);
    exp_done(1, 0, 50);
    start(13);
    begin
      int n = 0;
      while (!bus.done_o && n < 200) begin tick(); n++; end
      if (!bus.done_o) begin
        checks++; errors++;
        $display("FAIL done_cycle_start_timeout: no done within %0d cycles", n);
      end
    end
    bus.line_i = 8'd99; bus.line_start_i = 1'b1;
    tick();
    bus.line_start_i = 1'b0;
    chk("start_at_done_busy", 32'(bus.busy_o), 32'd0);
    tick();
    chk("start_at_done_busy2", 32'(bus.busy_o), 32'd0);
    chk("start_at_done_popped", 32'(done_q.size()), 32'd0);
    done_q.delete();

    // Reset during FETCH0: word 0 seen, then nothing more.
    exp_pair(11'h0A6, 0, 100);
    exp_done(1, 0, 50);
    start(13);
    begin
      int n = 0;
      while (!(bus.lb_we_o && !bus.lb_word_o) && n < 20) begin tick(); n++; end
      if (!(bus.lb_we_o && !bus.lb_word_o)) begin
        checks++; errors++;
        $display("FAIL fetch0_timeout: FETCH0 not reached in %0d cycles", n);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_lb_we", 32'(bus.lb_we_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_word0_seen", 32'(lb_q.size()), 32'd1);
    lb_q.delete();
    done_q.delete();
    repeat (60) tick();
    exp_pair(11'h0A6, 0, 100);
    exp_done(1, 0, 50);
    start(13);
    wait_done("after_rst");

    // Horizontal flip: hflip bit set, distinctive memory words.
    clear_attrs();
    attr_tab[0] = mk(1, 5, 100, 1, 10);
    mem[11'h0A6] = 32'h01234567;
    mem[11'h0A7] = 32'h89ABCDEF;
`ifdef VDE_SPRITE_HFLIP_EN
    exp_wr(11'h0A7, 0, 1'b0, 100, 32'hFEDCBA98);
    exp_wr(11'h0A6, 0, 1'b1, 100, 32'h76543210);
`else
    exp_wr(11'h0A6, 0, 1'b0, 100, 32'h01234567);
    exp_wr(11'h0A7, 0, 1'b1, 100, 32'h89ABCDEF);
`endif
    exp_done(1, 0, 50);
    start(13);
    wait_done("hflip");

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
